// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: result-source encoding, load funct3 codes,
// datapath width default and the writeback FSM state type.
package riscv_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10
    } result_src_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        IDLE    = 1'b0,
        WAIT_LD = 1'b1
    } wb_state_t;

endpackage

// File: rtl/wb_stage_load_ext.sv
// Load data extractor: picks the byte/halfword addressed by offset out of an
// aligned word and sign- or zero-extends it according to funct3.
module load_ext
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Misaligned accesses are not trapped; the offset bits select directly.
    assign byte_sel = word[8*offset +: 8];
    assign half_sel = word[16*offset[1] +: 16];

    always_comb begin
        data = word;
        case (funct3)
            F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: registered register-file write port, stalls upstream while a
// load response is pending. Define WB_LOAD_TIMEOUT_EN for the load-response timeout.
module wb_stage
    import riscv_pkg::*;
#(
    parameter int          XLEN           = XLEN_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_valid,
    input  logic            mem_reg_write,
    input  logic [4:0]      mem_rd,
    input  logic [1:0]      mem_result_src,
    input  logic [2:0]      mem_funct3,
    input  logic [XLEN-1:0] mem_alu_result,
    input  logic [XLEN-1:0] mem_pc_plus4,
    input  logic            ld_rsp_valid,
    input  logic [XLEN-1:0] ld_rsp_data,
    output logic            stall,
    output logic            we3,
    output logic [4:0]      a3,
    output logic [XLEN-1:0] wd3,
    output logic            ld_timeout
);

    wb_state_t       state_q, state_d;
    logic            we3_q, we3_d;
    logic [4:0]      a3_q, a3_d;
    logic [XLEN-1:0] wd3_q, wd3_d;
    logic            ld_rw_q, ld_rw_d;
    logic [4:0]      ld_rd_q, ld_rd_d;
    logic [2:0]      ld_f3_q, ld_f3_d;
    logic [1:0]      ld_off_q, ld_off_d;
    logic [XLEN-1:0] ld_ext;

    load_ext #(.XLEN(XLEN)) u_load_ext (
        .funct3 (ld_f3_q),
        .offset (ld_off_q),
        .word   (ld_rsp_data),
        .data   (ld_ext)
    );

`ifdef WB_LOAD_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign ld_timeout = timeout_q;
`else
    logic [31:0] unused_timeout_cycles;
    assign unused_timeout_cycles = TIMEOUT_CYCLES;
    assign ld_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            we3_q    <= 1'b0;
            a3_q     <= '0;
            wd3_q    <= '0;
            ld_rw_q  <= 1'b0;
            ld_rd_q  <= '0;
            ld_f3_q  <= '0;
            ld_off_q <= '0;
        end else begin
            state_q  <= state_d;
            we3_q    <= we3_d;
            a3_q     <= a3_d;
            wd3_q    <= wd3_d;
            ld_rw_q  <= ld_rw_d;
            ld_rd_q  <= ld_rd_d;
            ld_f3_q  <= ld_f3_d;
            ld_off_q <= ld_off_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        we3_d    = 1'b0;
        a3_d     = a3_q;
        wd3_d    = wd3_q;
        ld_rw_d  = ld_rw_q;
        ld_rd_d  = ld_rd_q;
        ld_f3_d  = ld_f3_q;
        ld_off_d = ld_off_q;
`ifdef WB_LOAD_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                // Responses seen here (including in the accept cycle) are dropped.
                if (mem_valid) begin
                    if (mem_result_src == 2'(RES_LOAD)) begin
                        ld_rw_d  = mem_reg_write;
                        ld_rd_d  = mem_rd;
                        ld_f3_d  = mem_funct3;
                        ld_off_d = mem_alu_result[1:0];
                        state_d  = WAIT_LD;
`ifdef WB_LOAD_TIMEOUT_EN
                        cnt_d    = '0;
`endif
                    end else begin
                        we3_d = mem_reg_write && (mem_rd != 5'd0);
                        a3_d  = mem_rd;
                        wd3_d = (mem_result_src == 2'(RES_PC4)) ? mem_pc_plus4 : mem_alu_result;
                    end
                end
            end
            WAIT_LD: begin
                if (ld_rsp_valid) begin
                    we3_d   = ld_rw_q && (ld_rd_q != 5'd0);
                    a3_d    = ld_rd_q;
                    wd3_d   = ld_ext;
                    state_d = IDLE;
                end
`ifdef WB_LOAD_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign stall = (state_q == WAIT_LD);
    assign we3   = we3_q;
    assign a3    = a3_q;
    assign wd3   = wd3_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: ALU/JAL/load writebacks, extension cases,
// reset during a pending load and (with WB_LOAD_TIMEOUT_EN) the timeout.
module tb_wb_stage;

    localparam int XLEN = 32;
    localparam int W    = 1 + 5 + XLEN;

    logic            clk = 1'b0;
    logic            rst;
    logic            mem_valid;
    logic            mem_reg_write;
    logic [4:0]      mem_rd;
    logic [1:0]      mem_result_src;
    logic [2:0]      mem_funct3;
    logic [XLEN-1:0] mem_alu_result;
    logic [XLEN-1:0] mem_pc_plus4;
    logic            ld_rsp_valid;
    logic [XLEN-1:0] ld_rsp_data;
    logic            stall;
    logic            we3;
    logic [4:0]      a3;
    logic [XLEN-1:0] wd3;
    logic            ld_timeout;

    logic [W-1:0] exp_q[$];
    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    wb_stage #(.XLEN(XLEN), .TIMEOUT_CYCLES(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_valid      (mem_valid),
        .mem_reg_write  (mem_reg_write),
        .mem_rd         (mem_rd),
        .mem_result_src (mem_result_src),
        .mem_funct3     (mem_funct3),
        .mem_alu_result (mem_alu_result),
        .mem_pc_plus4   (mem_pc_plus4),
        .ld_rsp_valid   (ld_rsp_valid),
        .ld_rsp_data    (ld_rsp_data),
        .stall          (stall),
        .we3            (we3),
        .a3             (a3),
        .wd3            (wd3),
        .ld_timeout     (ld_timeout)
    );

    // clock/reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [XLEN-1:0] ext_model(input logic [2:0] f3, input logic [1:0] off,
                                                  input logic [XLEN-1:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'((d >> (8 * off)) & 32'hFF);
        h = 16'((d >> (off[1] ? 16 : 0)) & 32'hFFFF);
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return d;
        endcase
    endfunction

    // driver tasks
    task automatic drive_op(input logic [4:0] rd, input logic rw, input logic [1:0] src,
                            input logic [2:0] f3, input logic [XLEN-1:0] alu,
                            input logic [XLEN-1:0] pc4);
        mem_valid      = 1'b1;
        mem_rd         = rd;
        mem_reg_write  = rw;
        mem_result_src = src;
        mem_funct3     = f3;
        mem_alu_result = alu;
        mem_pc_plus4   = pc4;
    endtask

    task automatic idle_in();
        mem_valid = 1'b0;
    endtask

    task automatic push_alu(input logic [4:0] rd, input logic rw, input logic [1:0] src,
                            input logic [XLEN-1:0] alu, input logic [XLEN-1:0] pc4);
        logic [XLEN-1:0] d;
        d = (src == 2'b10) ? pc4 : alu;
        exp_q.push_back({rw && (rd != 5'd0), rd, d});
        drive_op(rd, rw, src, 3'b010, alu, pc4);
    endtask

    task automatic expect_write(input string tag);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 64'(1), 64'(0));
        end else begin
            e = exp_q.pop_front();
            check({tag, "_we3"}, 64'(we3), 64'(e[W-1]));
            check({tag, "_a3"},  64'(a3),  64'(e[W-2 -: 5]));
            check({tag, "_wd3"}, 64'(wd3), 64'(e[XLEN-1:0]));
            check({tag, "_stall"}, 64'(stall), 64'(0));
        end
    endtask

    task automatic do_load(input string tag, input logic [4:0] rd, input logic rw,
                           input logic [2:0] f3, input logic [XLEN-1:0] addr,
                           input logic [XLEN-1:0] data, input int delay,
                           input logic [XLEN-1:0] exp_wd, input logic rsp_at_accept);
        exp_q.push_back({rw && (rd != 5'd0), rd, exp_wd});
        drive_op(rd, rw, 2'b01, f3, addr, 32'h0);
        ld_rsp_valid = rsp_at_accept;
        ld_rsp_data  = ~data;
        tick();
        ld_rsp_valid = 1'b0;
        for (int k = 1; k <= delay; k++) begin
            check({tag, "_wait_stall"}, 64'(stall), 64'(1));
            check({tag, "_wait_we3"}, 64'(we3), 64'(0));
            // Junk op offered while waiting must be ignored.
            if (k < delay) drive_op(5'd9, 1'b1, 2'b00, 3'b010, 32'hBAD0_0000 + k, 32'h0);
            else begin
                idle_in();
                ld_rsp_valid = 1'b1;
                ld_rsp_data  = data;
            end
            tick();
        end
        ld_rsp_valid = 1'b0;
        idle_in();
        expect_write(tag);
    endtask

    initial begin
        logic [2:0]      f3_tab[6];
        logic [XLEN-1:0] a, d;
        logic [4:0]      rd;
        f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};

        rst = 1'b1;
        mem_valid = 1'b0; mem_reg_write = 1'b0; mem_rd = '0; mem_result_src = '0;
        mem_funct3 = '0; mem_alu_result = '0; mem_pc_plus4 = '0;
        ld_rsp_valid = 1'b0; ld_rsp_data = '0;
        tick();
        tick();
        check("rst_we3", 64'(we3), 64'(0));
        check("rst_a3", 64'(a3), 64'(0));
        check("rst_wd3", 64'(wd3), 64'(0));
        check("rst_stall", 64'(stall), 64'(0));
        check("rst_timeout", 64'(ld_timeout), 64'(0));
        rst = 1'b0;
        tick();

        push_alu(5'd5, 1'b1, 2'b00, 32'h0000_1234, 32'h0); tick(); idle_in(); expect_write("alu_rd5");
        push_alu(5'd0, 1'b1, 2'b00, 32'hDEAD_BEEF, 32'h0); tick(); idle_in(); expect_write("alu_rd0");
        push_alu(5'd1, 1'b1, 2'b10, 32'h0000_0055, 32'h0000_0104); tick(); idle_in(); expect_write("jal");
        push_alu(5'd3, 1'b0, 2'b00, 32'h1111_2222, 32'h0); tick(); idle_in(); expect_write("no_rw");
        push_alu(5'd4, 1'b1, 2'b11, 32'hCAFE_0004, 32'h0000_0999); tick(); idle_in(); expect_write("src11");

        // back-to-back non-loads, one write per cycle
        for (int i = 0; i < 6; i++) begin
            push_alu(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                     2'($urandom_range(0, 1)) << 1, $urandom, $urandom);
            tick();
            expect_write($sformatf("b2b%0d", i));
        end
        idle_in();

        do_load("lb",  5'd7, 1'b1, 3'b000, 32'h0000_1003, 32'h80FF_FFFF, 2, 32'hFFFF_FF80, 1'b0);
        do_load("lbu", 5'd7, 1'b1, 3'b100, 32'h0000_1003, 32'h80FF_FFFF, 2, 32'h0000_0080, 1'b0);
        do_load("lh",  5'd8, 1'b1, 3'b001, 32'h0000_2002, 32'h8001_0000, 1, 32'hFFFF_8001, 1'b0);
        do_load("lhu", 5'd8, 1'b1, 3'b101, 32'h0000_2002, 32'h8001_0000, 3, 32'h0000_8001, 1'b1);
        do_load("lw_x0", 5'd0, 1'b1, 3'b010, 32'h0, 32'h1234_5678, 1, 32'h1234_5678, 1'b0);

        // load directly after a non-load
        push_alu(5'd10, 1'b1, 2'b00, 32'h0000_00AA, 32'h0); tick(); expect_write("pre_load");
        do_load("ld_after_alu", 5'd11, 1'b1, 3'b010, 32'h4, 32'h0BAD_F00D, 1, 32'h0BAD_F00D, 1'b0);

        for (int i = 0; i < 6; i++) begin
            a  = $urandom;
            d  = $urandom;
            rd = 5'($urandom_range(1, 31));
            do_load($sformatf("rld%0d", i), rd, 1'b1, f3_tab[i], a, d,
                    $urandom_range(1, 3), ext_model(f3_tab[i], a[1:0], d), 1'b0);
        end

        // response in IDLE is ignored
        ld_rsp_valid = 1'b1; ld_rsp_data = 32'hFFFF_FFFF; tick(); ld_rsp_valid = 1'b0;
        check("idle_rsp_we3", 64'(we3), 64'(0));
        check("idle_rsp_stall", 64'(stall), 64'(0));

        // reset while waiting for a load
        drive_op(5'd12, 1'b1, 2'b01, 3'b010, 32'h0, 32'h0); tick(); idle_in();
        check("rstld_stall", 64'(stall), 64'(1));
        rst = 1'b1; tick(); rst = 1'b0;
        check("rstld_stall_after", 64'(stall), 64'(0));
        ld_rsp_valid = 1'b1; ld_rsp_data = 32'h7777_7777; tick(); ld_rsp_valid = 1'b0;
        check("rstld_we3", 64'(we3), 64'(0));
        check("rstld_stall2", 64'(stall), 64'(0));
        check("rstld_wd3", 64'(wd3), 64'(0));

`ifdef WB_LOAD_TIMEOUT_EN
        drive_op(5'd13, 1'b1, 2'b01, 3'b010, 32'h0, 32'h0); tick(); idle_in();
        for (int k = 1; k <= 4; k++) begin
            check("to_stall", 64'(stall), 64'(1));
            check("to_flag_low", 64'(ld_timeout), 64'(0));
            tick();
        end
        check("to_flag", 64'(ld_timeout), 64'(1));
        check("to_stall_drop", 64'(stall), 64'(0));
        check("to_we3", 64'(we3), 64'(0));
        push_alu(5'd14, 1'b1, 2'b00, 32'h0000_4444, 32'h0); tick(); idle_in(); expect_write("to_next_alu");
        check("to_sticky", 64'(ld_timeout), 64'(1));
`else
        // without the timeout a load waits indefinitely
        drive_op(5'd13, 1'b1, 2'b01, 3'b010, 32'h0, 32'h0); tick(); idle_in();
        repeat (300) tick();
        check("nto_stall", 64'(stall), 64'(1));
        check("nto_flag", 64'(ld_timeout), 64'(0));
        exp_q.push_back({1'b1, 5'd13, 32'h0000_5A5A});
        ld_rsp_valid = 1'b1; ld_rsp_data = 32'h0000_5A5A; tick(); ld_rsp_valid = 1'b0;
        expect_write("nto_late_rsp");
`endif

        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
